decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode stage sitting directly upstream of the Execute stage.
- Accepts one instruction per cycle from fetch and reads operands from an internal 8-entry register file.
- Tracks in-flight register writes with a scoreboard and stalls fetch on RAW hazards.
- Drives registered enable_ex, src1, src2, imm and control_in to Execute; takes writeback results back in.

Parameters:
- instr_wd, default `INSTR_WIDTH (16): instruction width.
- reg_wd, default `REGISTER_WIDTH (16): register/data width.
- imm_wd, default `IMMEDIATE_WIDTH (6): raw immediate field width.
- nregs, default 8: register count; index width is 3.

Ports:
- clock  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- instr_in  input  instr_wd  instruction from fetch.
- instr_valid  input  1  instr_in is valid.
- stall_out  output  1  combinational; instruction not accepted this cycle, fetch must hold.
- wb_en  input  1  register write from writeback.
- wb_addr  input  3  writeback destination register.
- wb_data  input  reg_wd  writeback data.
- enable_ex  output  1  Execute holds a valid instruction.
- src1  output  reg_wd  operand A.
- src2  output  reg_wd  operand B; store data for ST.
- imm  output  reg_wd  sign-extended immediate.
- control_in  output  7  control word to Execute.
- rd_out  output  3  destination tag, travels with the instruction to writeback.

Behaviour:
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 ADDI: rs1 + imm.
  - 7 LD: rd <= mem[rs1 + imm].
  - 8 ST: mem[rs1 + imm] <= reg[rd].
  - 9–15 are illegal and decode as NOP.
- control_in: [2:0] alu_op (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR); [3] use_imm; [4] mem_read; [5] mem_write; [6] reg_write.
- ST sets src2 = reg[rd] (the store data).
- Source registers used:
  - R-type: rs1, rs2.
  - ADDI and LD: rs1.
  - ST: rs1 and rd.
  - NOP: none.
- R0 reads 0; writes to R0 are ignored; R0 is never pending.
- Scoreboard, one pending bit per register:
  - Set when a reg_write instruction with rd != 0 is accepted.
  - Cleared when wb_en is high and wb_addr matches.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: a used source register is pending and is not being written this cycle. stall_out = instr_valid & hazard.
- Accept condition: instr_valid & !stall_out.
- On accept, next edge: enable_ex <= 1; src1, src2, imm, control_in, rd_out <= decoded values. Latency is 1 cycle.
- Otherwise, next edge: enable_ex <= 0 and control_in <= 0 (bubble). src1, src2, imm and rd_out hold.
- Writeback bypass: if wb_en and wb_addr equals a source register in the same cycle, wb_data is used and the hazard is cleared.
- Illegal opcode: accepted as a bubble (enable_ex 0); no scoreboard change.
- Reset, asynchronous:
  - All outputs 0, register file 0, scoreboard clear.
  - stall_out = 0 while instr_valid = 0.
  - An instruction accepted mid-cycle is discarded.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: same-cycle writeback bypass as described above.
- Undefined: no bypass. A source register cleared by writeback this cycle still stalls one cycle and is read from the register file next cycle.
- Scoreboard clear timing is identical in both builds.

Decomposition:
- decode_pkg holds:
  - opcode enum.
  - alu_op enum.
  - Control bit index constants CTRL_ALU_LSB, CTRL_USE_IMM, CTRL_MEM_RD, CTRL_MEM_WR, CTRL_REG_WR.
  - Field position constants.
- One sub-module, decode_regfile: nregs x reg_wd, 2 read ports, 1 write port, R0 hardwired to 0, optional bypass.
- Scoreboard and decode logic stay in decode_stage.

Test Plan:
- Reset → all outputs 0. Then ADDI R1,R0,#-3 → next cycle enable_ex=1, imm=16'hFFFD, control_in=7'b1001000, rd_out=1.
- Write R2=5 via writeback, then ADD R3,R2,R2 → src1=src2=5, control_in=7'b1000000.
- LD R4 accepted, then ADD R5,R4,R1 → stall_out=1 and enable_ex=0 each cycle until wb_en with addr 4 and data 9. With bypass: accepted that cycle, src1=9. Without bypass: accepted one cycle later.
- ST R6,[R1+2] with R6 pending, then writeback R6=0x1234 → src2=0x1234, control_in[5]=1, no reg_write.
- Write to R0 via writeback, and opcode 12 → R0 still reads 0; opcode 12 produces enable_ex=0, stall_out=0, scoreboard unchanged.
- Reset asserted while stalled with pending bits set → outputs and scoreboard cleared immediately; next ADD proceeds without stall.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU ops, control-word bit positions and instruction field positions.
// Defining DECODE_WB_BYPASS_EN enables the same-cycle writeback bypass.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 16
`endif
`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 16
`endif
`ifndef IMMEDIATE_WIDTH
`define IMMEDIATE_WIDTH 6
`endif
package decode_pkg;
   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_ADDI = 4'd6,
      OP_LD   = 4'd7,
      OP_ST   = 4'd8
   } opcode_e;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;
   localparam int CTRL_ALU_LSB = 0;
   localparam int CTRL_USE_IMM = 3;
   localparam int CTRL_MEM_RD  = 4;
   localparam int CTRL_MEM_WR  = 5;
   localparam int CTRL_REG_WR  = 6;
   localparam int CTRL_WD      = 7;
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IDX_WD  = 3;
`ifdef DECODE_WB_BYPASS_EN
   localparam bit WB_BYPASS = 1'b1;
`else
   localparam bit WB_BYPASS = 1'b0;
`endif
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: register file with two read ports, one write port, R0 tied to zero, optional write-to-read bypass.
// Bypass is present only when DECODE_WB_BYPASS_EN is defined.
module decode_regfile
   import decode_pkg::*;
#(
   parameter int reg_wd = 16,
   parameter int nregs  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [2:0]        wa,
   input  logic [reg_wd-1:0] wd,
   input  logic [2:0]        ra1,
   input  logic [2:0]        ra2,
   output logic [reg_wd-1:0] rd1,
   output logic [reg_wd-1:0] rd2
);
   logic [reg_wd-1:0] mem [nregs];
   // storage: cleared on reset, R0 writes dropped
   always_ff @(posedge clock or posedge reset)
      if (reset)
         for (int i = 0; i < nregs; i++) mem[i] <= '0;
      else if (we && wa != '0)
         mem[wa] <= wd;
   // reads: R0 is zero, otherwise the write data when bypassing a same-cycle write
   always_comb begin
      rd1 = (ra1 == '0) ? '0 : (WB_BYPASS && we && wa == ra1) ? wd : mem[ra1];
      rd2 = (ra2 == '0) ? '0 : (WB_BYPASS && we && wa == ra2) ? wd : mem[ra2];
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register file read, RAW scoreboard stall and registered Execute interface.
// Defining DECODE_WB_BYPASS_EN lets a same-cycle writeback satisfy a pending source.
module decode_stage
   import decode_pkg::*;
#(
   parameter int instr_wd = `INSTR_WIDTH,
   parameter int reg_wd   = `REGISTER_WIDTH,
   parameter int imm_wd   = `IMMEDIATE_WIDTH,
   parameter int nregs    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [instr_wd-1:0] instr_in,
   input  logic                instr_valid,
   output logic                stall_out,
   input  logic                wb_en,
   input  logic [2:0]          wb_addr,
   input  logic [reg_wd-1:0]   wb_data,
   output logic                enable_ex,
   output logic [reg_wd-1:0]   src1,
   output logic [reg_wd-1:0]   src2,
   output logic [reg_wd-1:0]   imm,
   output logic [CTRL_WD-1:0]  control_in,
   output logic [2:0]          rd_out
);
   localparam logic [nregs-1:0] ONE = {{(nregs-1){1'b0}}, 1'b1};
   logic [3:0]         op;
   logic [2:0]         rd, rs1, rs2, a2;
   logic               is_r, is_addi, is_ld, is_st, legal, use1, use2, hazard, accept, issue;
   alu_op_e            alu;
   logic [CTRL_WD-1:0] ctrl;
   logic [reg_wd-1:0]  imm_x, rd1, rd2;
   logic [nregs-1:0]   pend, set_m, clr_m, pend_n;
   assign op  = instr_in[OP_MSB:OP_LSB];
   assign rd  = instr_in[RD_LSB +: IDX_WD];
   assign rs1 = instr_in[RS1_LSB +: IDX_WD];
   assign rs2 = instr_in[RS2_LSB +: IDX_WD];
   assign imm_x = {{(reg_wd-imm_wd){instr_in[imm_wd-1]}}, instr_in[imm_wd-1:0]};
   // opcode decode into control word and source-register usage; ST reads rd as store data
   always_comb begin
      is_r    = (op >= OP_ADD) && (op <= OP_XOR);
      is_addi = op == OP_ADDI;
      is_ld   = op == OP_LD;
      is_st   = op == OP_ST;
      legal   = op <= OP_ST;
      alu = (op == OP_SUB) ? ALU_SUB : (op == OP_AND) ? ALU_AND :
            (op == OP_OR)  ? ALU_OR  : (op == OP_XOR) ? ALU_XOR : ALU_ADD;
      ctrl = '0;
      ctrl[CTRL_ALU_LSB +: 3] = is_r ? alu : ALU_ADD;
      ctrl[CTRL_USE_IMM] = is_addi | is_ld | is_st;
      ctrl[CTRL_MEM_RD]  = is_ld;
      ctrl[CTRL_MEM_WR]  = is_st;
      ctrl[CTRL_REG_WR]  = is_r | is_addi | is_ld;
      use1 = is_r | is_addi | is_ld | is_st;
      use2 = is_r | is_st;
      a2   = is_st ? rd : rs2;
   end
   // RAW hazard against the scoreboard and next scoreboard state (set beats clear, R0 never pending)
   always_comb begin
      hazard = (use1 && pend[rs1] && !(WB_BYPASS && wb_en && wb_addr == rs1)) ||
               (use2 && pend[a2]  && !(WB_BYPASS && wb_en && wb_addr == a2));
      stall_out = instr_valid & hazard;
      accept = instr_valid & ~hazard;
      issue  = accept & legal;
      set_m  = (issue && ctrl[CTRL_REG_WR] && rd != '0) ? ONE << rd : '0;
      clr_m  = wb_en ? ONE << wb_addr : '0;
      pend_n = ((pend & ~clr_m) | set_m) & ~ONE;
   end
   decode_regfile #(.reg_wd(reg_wd), .nregs(nregs)) u_rf (
      .clock(clock),
      .reset(reset),
      .we(wb_en),
      .wa(wb_addr),
      .wd(wb_data),
      .ra1(rs1),
      .ra2(a2),
      .rd1(rd1),
      .rd2(rd2)
   );
   // Execute interface: load on issue, otherwise a bubble with operands held
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         pend       <= '0;
         enable_ex  <= 1'b0;
         control_in <= '0;
         src1       <= '0;
         src2       <= '0;
         imm        <= '0;
         rd_out     <= '0;
      end else begin
         pend       <= pend_n;
         enable_ex  <= issue;
         control_in <= issue ? ctrl : '0;
         if (issue) begin
            src1   <= rd1;
            src2   <= rd2;
            imm    <= imm_x;
            rd_out <= rd;
         end
      end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus hand-written reset-during-stall sequence for decode_stage.
module tb_decode_stage;
   logic        clock = 0, reset = 1, instr_valid = 0, wb_en = 0;
   logic [15:0] instr_in = 0, wb_data = 0;
   logic [2:0]  wb_addr = 0;
   logic        stall_out, enable_ex;
   logic [15:0] src1, src2, imm;
   logic [6:0]  control_in;
   logic [2:0]  rd_out;
   int total = 0, bad = 0;

   decode_stage dut (
      .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
      .stall_out(stall_out), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .enable_ex(enable_ex), .src1(src1), .src2(src2), .imm(imm),
      .control_in(control_in), .rd_out(rd_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic v; logic [15:0] ins; logic we; logic [2:0] wa; logic [15:0] wd;
      logic st; logic en; logic [15:0] s1, s2, im; logic [6:0] ct; logic [2:0] rd;
   } vec_t;
   vec_t tv[17];

   function automatic vec_t mk(logic v, logic [15:0] ins, logic we, logic [2:0] wa, logic [15:0] wd,
                               logic st, logic en, logic [15:0] s1, s2, im, logic [6:0] ct, logic [2:0] rd);
      vec_t t;
      t.v = v; t.ins = ins; t.we = we; t.wa = wa; t.wd = wd;
      t.st = st; t.en = en; t.s1 = s1; t.s2 = s2; t.im = im; t.ct = ct; t.rd = rd;
      return t;
   endfunction

   function automatic logic [15:0] er(logic [3:0] op, logic [2:0] rd, rs1, rs2);
      return {op, rd, rs1, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] ei(logic [3:0] op, logic [2:0] rd, rs1, logic [5:0] im);
      return {op, rd, rs1, im};
   endfunction

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [15:0] s1, s2, im,
                          input logic [6:0] ct, input logic [2:0] rd);
      chk({tag, " enable_ex"}, {15'd0, enable_ex}, {15'd0, en});
      chk({tag, " src1"}, src1, s1);
      chk({tag, " src2"}, src2, s2);
      chk({tag, " imm"}, imm, im);
      chk({tag, " control_in"}, {9'd0, control_in}, {9'd0, ct});
      chk({tag, " rd_out"}, {13'd0, rd_out}, {13'd0, rd});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0]  = mk(1, ei(6,1,0,6'h3d), 0,0,0,       0,1, 16'h0000,16'h0000,16'hFFFD,7'h48,1);
      tv[1]  = mk(0, 0,               1,1,16'hFFFD,0,0, 16'h0000,16'h0000,16'hFFFD,7'h00,1);
      tv[2]  = mk(0, 0,               1,2,16'h0005,0,0, 16'h0000,16'h0000,16'hFFFD,7'h00,1);
      tv[3]  = mk(1, er(1,3,2,2),     0,0,0,       0,1, 16'h0005,16'h0005,16'h0010,7'h40,3);
      tv[4]  = mk(1, ei(7,4,1,0),     0,0,0,       0,1, 16'hFFFD,16'h0000,16'h0000,7'h58,4);
      tv[5]  = mk(1, er(1,5,4,1),     0,0,0,       1,0, 16'hFFFD,16'h0000,16'h0000,7'h00,4);
      tv[6]  = mk(1, er(1,5,4,1),     0,0,0,       1,0, 16'hFFFD,16'h0000,16'h0000,7'h00,4);
`ifdef DECODE_WB_BYPASS_EN
      tv[7]  = mk(1, er(1,5,4,1),     1,4,16'h0009,0,1, 16'h0009,16'hFFFD,16'h0008,7'h40,5);
`else
      tv[7]  = mk(1, er(1,5,4,1),     1,4,16'h0009,1,0, 16'hFFFD,16'h0000,16'h0000,7'h00,4);
`endif
      tv[8]  = mk(1, er(1,5,4,1),     0,0,0,       0,1, 16'h0009,16'hFFFD,16'h0008,7'h40,5);
      tv[9]  = mk(1, ei(6,6,0,1),     0,0,0,       0,1, 16'h0000,16'h0000,16'h0001,7'h48,6);
      tv[10] = mk(1, ei(8,6,1,2),     0,0,0,       1,0, 16'h0000,16'h0000,16'h0001,7'h00,6);
`ifdef DECODE_WB_BYPASS_EN
      tv[11] = mk(1, ei(8,6,1,2),     1,6,16'h1234,0,1, 16'hFFFD,16'h1234,16'h0002,7'h28,6);
`else
      tv[11] = mk(1, ei(8,6,1,2),     1,6,16'h1234,1,0, 16'h0000,16'h0000,16'h0001,7'h00,6);
`endif
      tv[12] = mk(1, ei(8,6,1,2),     0,0,0,       0,1, 16'hFFFD,16'h1234,16'h0002,7'h28,6);
      tv[13] = mk(0, 0,               1,0,16'hBEEF,0,0, 16'hFFFD,16'h1234,16'h0002,7'h00,6);
      tv[14] = mk(1, er(1,7,0,0),     1,0,16'hBEEF,0,1, 16'h0000,16'h0000,16'h0000,7'h40,7);
      tv[15] = mk(1, 16'hC480,        0,0,0,       0,0, 16'h0000,16'h0000,16'h0000,7'h00,7);
      tv[16] = mk(1, er(1,1,2,2),     0,0,0,       0,1, 16'h0005,16'h0005,16'h0010,7'h40,1);

      #12;
      chk("reset stall_out", {15'd0, stall_out}, 16'd0);
      chk_out("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clock) reset = 0;
      @(posedge clock) #1;

      for (int i = 0; i < 17; i++) begin
         instr_valid = tv[i].v; instr_in = tv[i].ins;
         wb_en = tv[i].we; wb_addr = tv[i].wa; wb_data = tv[i].wd;
         #1 chk($sformatf("v%0d stall_out", i), {15'd0, stall_out}, {15'd0, tv[i].st});
         @(posedge clock) #1;
         chk_out($sformatf("v%0d", i), tv[i].en, tv[i].s1, tv[i].s2, tv[i].im, tv[i].ct, tv[i].rd);
      end

      instr_valid = 1; instr_in = ei(6,2,0,7); wb_en = 0;
      @(posedge clock) #1;
      chk("pre-reset addi enable_ex", {15'd0, enable_ex}, 16'd1);
      chk("pre-reset addi imm", imm, 16'h0007);
      instr_in = er(1,3,2,2);
      #1 chk("pre-reset stall_out", {15'd0, stall_out}, 16'd1);
      #1 reset = 1;
      #1 chk("async reset stall_out", {15'd0, stall_out}, 16'd0);
      chk_out("async reset", 0, 0, 0, 0, 0, 0);
      @(negedge clock) reset = 0;
      #1 chk("post-reset stall_out", {15'd0, stall_out}, 16'd0);
      @(posedge clock) #1;
      chk_out("post-reset add", 1, 0, 0, 16'h0010, 7'h40, 3);
      instr_valid = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
